// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - shared segment codes, scan states and digit-count derivation
package bcd_scan_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Number of BCD digits needed for the product of two n_bits operands;
    // the multiplier uses the same function so the bus widths always agree.
    function automatic int calc_digits(input int n_bits);
        return ((2 * n_bits) / 3) + 1;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - result bus from the multiplier and display pin bundle
interface bcd_scan_display_if
    import bcd_scan_display_pkg::*;
#(
    parameter int DIGITS = calc_digits(5)
) ();

    logic [4*DIGITS-1:0] bcd;
    logic                finish;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                valid;
    logic                err;

    modport master (
        output bcd,
        output finish,
        input  seg,
        input  an,
        input  valid,
        input  err
    );

    modport slave (
        input  bcd,
        input  finish,
        output seg,
        output an,
        output valid,
        output err
    );

endinterface

// File: rtl/bcd_scan_display_seg7_decode.sv
// rtl/bcd_scan_display_seg7_decode.sv - nibble to active-low 7-segment pattern
module seg7_decode
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins; anything outside 0..9 is shown as a dash
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - latches the multiplier BCD result and scans it onto a 7-segment display
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int N_BITS      = 5,
    parameter int DIGITS      = calc_digits(N_BITS),
    parameter int REFRESH_DIV = 1000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    bcd_scan_display_if.slave bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_t              state_q;
    state_t              state_d;
    logic                finish_d_q;
    logic [4*DIGITS-1:0] latch_q;
    logic                valid_q;
    logic                err_q;
    logic [PW-1:0]       presc_q;
    logic [IW-1:0]       idx_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;

    logic                load;
    logic                bcd_has_err;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   upper_zero;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                digit_blank;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;

    // A load is the rising edge of the multiplier's finish level
    assign load = bus.finish & ~finish_d_q;

    // Flag any incoming nibble that is not a decimal digit
    always_comb begin
        bcd_has_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) begin
                bcd_has_err = 1'b1;
            end
        end
    end

    // Split the latch into nibbles and mark digits whose own and all higher nibbles are zero
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = latch_q[4*i +: 4];
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (nib[i] == 4'd0);
            upper_zero[i] = zero_run;
        end
    end

    assign cur_nib     = nib[idx_q];
    assign digit_blank = LZ_BLANK && (idx_q != '0) && upper_zero[idx_q];

    seg7_decode u_decode (
        .nibble (cur_nib),
        .blank  (digit_blank),
        .seg    (dec_seg)
    );

    // Next-state: leave IDLE on the first load, then scan until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SCAN;
            SCAN:    state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    // Display drive: dark in IDLE and during the prescaler==0 anti-ghost slot
    always_comb begin
        seg_nxt = SEG_BLANK;
        an_nxt  = '1;
        if (state_q == SCAN && presc_q != '0) begin
            seg_nxt = dec_seg;
            if (!digit_blank) begin
                an_nxt[idx_q] = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch, prescaler, digit index and registered display outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            finish_d_q <= 1'b0;
            latch_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            finish_d_q <= bus.finish;
            if (load) begin
                latch_q <= bus.bcd;
                valid_q <= 1'b1;
                err_q   <= bcd_has_err;
            end
            // A reload mid-scan leaves the prescaler and index alone so the scan never restarts
            if (state_q == SCAN) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
            seg_q <= seg_nxt;
            an_q  <= an_nxt;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display
module tb_bcd_scan_display;
    import bcd_scan_display_pkg::*;

    localparam int NB = 5;
    localparam int D  = calc_digits(NB);
    localparam int R  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           fin;
    logic [4*D-1:0] bcd_v;

    bcd_scan_display_if #(.DIGITS(D)) if_lz  ();
    bcd_scan_display_if #(.DIGITS(D)) if_all ();

    assign if_lz.bcd     = bcd_v;
    assign if_lz.finish  = fin;
    assign if_all.bcd    = bcd_v;
    assign if_all.finish = fin;

    bcd_scan_display #(.N_BITS(NB), .DIGITS(D), .REFRESH_DIV(R), .LZ_BLANK(1'b1)) dut_lz (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if_lz.slave)
    );

    bcd_scan_display #(.N_BITS(NB), .DIGITS(D), .REFRESH_DIV(R), .LZ_BLANK(1'b0)) dut_all (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if_all.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: scan position is just edges elapsed since the first load
    int             edge_n = 0;
    bit             m_loaded = 1'b0;
    bit             m_fin_prev = 1'b0;
    int             m_start = 0;
    logic [4*D-1:0] m_val = '0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic [6:0] obs_lz  [D];
    logic [6:0] obs_all [D];

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0][6:0]  segs;
        bit               err;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
    endtask

    function automatic logic [6+D:0] exp_disp(input bit lz);
        logic [6:0]   s;
        logic [D-1:0] a;
        int m, d, v;
        s = 7'h7F;
        a = '1;
        if (m_loaded) begin
            m = edge_n - 1 - m_start;
            d = (m / R) % D;
            if (m % R != 0) begin
                v = int'((m_val >> (4 * d)) & 16'hF);
                if (v > 9) begin
                    s = 7'b0111111;
                    a[d] = 1'b0;
                end else if (!(lz && d > 0 && (m_val >> (4 * d)) == 0)) begin
                    s = seg_tab[v];
                    a[d] = 1'b0;
                end
            end
        end
        return {s, a};
    endfunction

    task automatic step();
        logic [6+D:0] e_lz, e_all;
        bit           e_err;
        @(posedge clk);
        #1;
        edge_n++;
        if (!rst_n) begin
            e_lz       = {7'h7F, {D{1'b1}}};
            e_all      = e_lz;
            m_loaded   = 1'b0;
            m_fin_prev = 1'b0;
            m_val      = '0;
        end else begin
            e_lz  = exp_disp(1'b1);
            e_all = exp_disp(1'b0);
            if (fin && !m_fin_prev) begin
                if (!m_loaded) m_start = edge_n;
                m_loaded = 1'b1;
                m_val    = bcd_v;
            end
            m_fin_prev = fin;
        end
        e_err = 1'b0;
        for (int k = 0; k < D; k++) if (((m_val >> (4 * k)) & 16'hF) > 9) e_err = 1'b1;
        check("lz_seg_an",  {if_lz.seg, if_lz.an},   e_lz);
        check("all_seg_an", {if_all.seg, if_all.an}, e_all);
        check("lz_valid",   if_lz.valid,  m_loaded);
        check("all_valid",  if_all.valid, m_loaded);
        check("lz_err",     if_lz.err,    e_err);
        check("all_err",    if_all.err,   e_err);
        for (int k = 0; k < D; k++) begin
            if (!if_lz.an[k])  obs_lz[k]  = if_lz.seg;
            if (!if_all.an[k]) obs_all[k] = if_all.seg;
        end
    endtask

    task automatic load(input logic [15:0] v);
        fin = 1'b0;
        step();
        bcd_v = v;
        fin = 1'b1;
        step();
    endtask

    initial begin
        int k;
        vt[0] = '{16'h0780, {7'h7F,      7'b1111000, 7'b0000000, 7'b1000000}, 1'b0};
        vt[1] = '{16'h0169, {7'h7F,      7'b1111001, 7'b0000010, 7'b0010000}, 1'b0};
        vt[2] = '{16'h0000, {7'h7F,      7'h7F,      7'h7F,      7'b1000000}, 1'b0};
        vt[3] = '{16'h0A12, {7'h7F,      7'b0111111, 7'b1111001, 7'b0100100}, 1'b1};
        vt[4] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
        vt[5] = '{16'h9005, {7'b0010000, 7'b1000000, 7'b1000000, 7'b0010010}, 1'b0};
        vt[6] = '{16'h00F0, {7'h7F,      7'h7F,      7'b0111111, 7'b1000000}, 1'b1};

        rst_n = 1'b0;
        fin   = 1'b0;
        bcd_v = '0;
        repeat (3) step();
        check("reset_seg",   if_lz.seg,   7'h7F);
        check("reset_an",    if_lz.an,    4'hF);
        check("reset_valid", if_lz.valid, 1'b0);
        rst_n = 1'b1;
        repeat (10) step();
        check("idle_an", if_lz.an, 4'hF);

        // finish held high must not reload while bcd changes
        load(16'h0780);
        repeat (5) step();
        bcd_v = 16'h0169;
        repeat (20) step();

        for (int i = 0; i < 7; i++) begin
            load(vt[i].bcd);
            for (int d = 0; d < D; d++) begin
                obs_lz[d]  = 7'h7F;
                obs_all[d] = 7'h7F;
            end
            repeat (R * D + 1) step();
            for (int d = 0; d < D; d++) check($sformatf("vec%0d_digit%0d", i, d), obs_lz[d], vt[i].segs[d]);
            check($sformatf("vec%0d_err", i), if_lz.err, vt[i].err);
            if (vt[i].bcd == 16'h0000)
                for (int d = 0; d < D; d++) check($sformatf("nolz_zero_digit%0d", d), obs_all[d], 7'b1000000);
        end

        // reset while digit 2 is lit, then a fresh load starts at digit 0
        load(16'h1234);
        k = 0;
        while (if_lz.an != 4'b1011 && k < 100) begin
            step();
            k++;
        end
        check("reach_digit2", k < 100, 1'b1);
        rst_n = 1'b0;
        step();
        check("midscan_reset_seg",   if_lz.seg,   7'h7F);
        check("midscan_reset_an",    if_lz.an,    4'hF);
        check("midscan_reset_valid", if_lz.valid, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();
        load(16'h0042);
        k = 0;
        while (if_lz.an == 4'hF && k < 20) begin
            step();
            k++;
        end
        check("first_lit_is_digit0", if_lz.an, 4'b1110);

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 5) == 0) fin = ~fin;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: for (int d = 0; d < D; d++) bcd_v[4*d +: 4] = 4'($urandom_range(0, 9));
                    1: bcd_v = 16'($urandom);
                    default: bcd_v = 16'($urandom_range(0, 255));
                endcase
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the sequential multiplier's packed BCD result and its finish strobe.
- Captures the BCD word on the rising edge of finish and time-multiplexes it onto a common-anode 7-segment display, one digit at a time.
- Applies leading-zero blanking and flags non-BCD nibbles.
- Sits between the multiplier and the board display pins.

Parameters:
- N_BITS, 5, multiplier operand width; must match the upstream multiplier.
- DIGITS, ((2*N_BITS)/3)+1, number of BCD digits; 4 at default. BCD input width is 4*DIGITS.
- REFRESH_DIV, 1000, clocks each digit stays active, >=2.
- LZ_BLANK, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- bcd  in  4*DIGITS  packed BCD from the multiplier; digit 0 in bits [3:0].
- finish  in  1  multiplier done level; a 0->1 transition triggers a load.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  out  DIGITS  digit enables, active-low, one-hot-low when on, registered.
- valid  out  1  high once a value has been loaded since reset.
- err  out  1  high while the latched value contains any nibble >9.

Behaviour:
- Reset (reset=0 at clk edge), all synchronous:
  - seg=7'h7F, an=all ones, valid=0, err=0.
  - Latched value=0, prescaler=0, digit index=0, finish_d=0, state=IDLE.
- Load detect:
  - finish_d is registered each cycle; load = finish & ~finish_d.
  - On load, latch bcd, set valid=1, and set err = OR over nibbles of (nibble>9).
  - finish held high does not reload. finish already high as reset deasserts counts as an edge, because finish_d=0.
- FSM:
  - IDLE: an all ones, seg=7'h7F. Go to SCAN on load.
  - SCAN: stays in SCAN until reset. A new load during SCAN replaces the latch without resetting the prescaler or digit index, so there is no scan restart or flicker.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances; index DIGITS-1 wraps to 0.
- Anti-ghost gap: in the cycle the prescaler equals 0 in SCAN, an=all ones. Each digit is therefore lit REFRESH_DIV-1 of every REFRESH_DIV cycles.
- Outputs are registered from the current latch, index and prescaler, so seg/an lag internal state by 1 clk. A load latched at edge t is visible on the active digit from edge t+1.
- Digit decode for index i, nibble v:
  - v>9 -> dash, 7'b0111111.
  - Leading-zero blank (LZ_BLANK=1, i>0, v and all higher nibbles ==0) -> 7'h7F, and that digit's an bit stays 1.
  - Otherwise the segment pattern for v.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset mid-scan: the next edge forces the reset values and IDLE. The previous value is not retained.
- Simultaneous load and digit advance on the same edge: both take effect. The next digit shows the new value.

Decomposition:
- Shared package:
  - Segment pattern constants: SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - State enum: IDLE, SCAN.
  - DIGITS derivation function from N_BITS, shared with the multiplier so widths cannot diverge.
- Sub-module seg7_decode: combinational 4-bit nibble plus blank flag to 7-bit active-low pattern. It is instantiated once on the muxed nibble.

Test Plan (REFRESH_DIV=4, N_BITS=5):
- Reset held 3 clks, finish=0 -> seg=7F, an=F, valid=0; after release, still blank indefinitely.
- bcd=16'h0780, finish 0->1 -> valid=1, err=0.
  - Across one full scan: digit0 seg=1000000, digit1 0000000, digit2 1111000.
  - Digit3 an bit never low.
  - an high on every prescaler==0 cycle.
- finish held high 20 clks while bcd changes to 16'h0169 -> display stays 780; drop finish, raise again -> shows 169 (1111001, 0000010, 0010000), with no index reset at the load.
- bcd=16'h0000 loaded -> only digit0 lit, showing 1000000. With LZ_BLANK=0, all four digits show 0.
- bcd=16'h0A12 loaded -> err=1, digit2 shows 0111111, digits 1/0 show 1 and 2.
- reset asserted mid-scan on a digit2 cycle -> next edge seg=7F, an=F, valid=0. A fresh load scans starting from digit 0.
